// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-back scheduler.
package regfile_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEFAULT = 5;
  localparam int unsigned DATA_WIDTH_DEFAULT    = 32;

  typedef logic [ADDRESS_WIDTH_DEFAULT-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0]    reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-input round-robin arbiter: a lone request always wins, contention goes
// to the source that did not win the previous transfer.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  wb_src_e last_grant;

  always_comb begin
    grant = '0;
    if (req[SRC_ALU] && req[SRC_LSU]) begin
      if (last_grant == SRC_LSU) grant[SRC_ALU] = 1'b1;
      else                       grant[SRC_LSU] = 1'b1;
    end else begin
      grant = req;
    end
  end

  // A grant is always a transfer, so last_grant follows the granted source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_LSU;
    end else if (grant[SRC_ALU]) begin
      last_grant <= SRC_ALU;
    end else if (grant[SRC_LSU]) begin
      last_grant <= SRC_LSU;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between ALU and LSU write-backs and
// keeps a per-register busy scoreboard for decode hazard stalls.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  output logic                        alu_ready,
  input  logic                        lsu_valid,
  input  logic [ADDRESS_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]       lsu_data,
  output logic                        lsu_ready,
  input  logic                        issue_valid,
  input  logic                        issue_wr,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs2,
  output logic                        issue_stall,
  output logic                        WE3,
  output logic [ADDRESS_WIDTH-1:0]    ad3,
  output logic [DATA_WIDTH-1:0]       WD3,
  output logic [(1<<ADDRESS_WIDTH)-1:0] busy
);

  localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [1:0]               grant;
  logic                     xfer;
  logic [ADDRESS_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     set_en;
  logic [NUM_REGS-1:0]      busy_next;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_valid, alu_valid}),
    .grant (grant)
  );

  assign alu_ready = grant[SRC_ALU];
  assign lsu_ready = grant[SRC_LSU];
  assign xfer      = |grant;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (grant[SRC_LSU]) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
  end

  // x0 write-backs complete the handshake but never assert the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE3 <= 1'b0;
      ad3 <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= xfer && (sel_rd != ZERO_ADDR);
      if (xfer) begin
        ad3 <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

  assign issue_stall = issue_valid &&
                       (busy[issue_rs1] || busy[issue_rs2] || (issue_wr && busy[issue_rd]));

  assign set_en = issue_valid && !issue_stall && issue_wr && (issue_rd != ZERO_ADDR);

  // Clear lands with the register file write; a coincident set takes priority.
  always_comb begin
    busy_next = busy;
    if (WE3) busy_next[ad3] = 1'b0;
    if (set_en) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  set_clear_collision : assert property (
    @(posedge clk) disable iff (!rst_n) !(set_en && WE3 && (issue_rd == ad3))
  );

endmodule
